// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-pass shift sequencer.
// State encoding and the shifter geometry it is built around.
package shift_seq_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned SHAMT_W  = 3;
    localparam int unsigned MAX_STEP = 2**SHAMT_W - 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPass = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational barrel shifter: left, logical right or arithmetic right by shamt.
// AL only affects right shifts.
module barrel_shifter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               LR,
    input  logic               AL,
    output logic [WIDTH-1:0]   dout
);

    always_comb begin
        dout = din;
        if (LR) begin
            dout = din << shamt;
        end else if (AL) begin
            dout = WIDTH'($signed(din) >>> shamt);
        end else begin
            dout = din >> shamt;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Sequencer that splits a 0..31 shift into passes of at most MAX_STEP bits,
// feeding each shifter result back until the full amount has been applied.
module shift_seq #(
    parameter int unsigned WIDTH   = shift_seq_pkg::WIDTH,
    parameter int unsigned SHAMT_W = shift_seq_pkg::SHAMT_W,
    parameter int unsigned AMT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_din,
    input  logic [AMT_W-1:0]   in_amt,
    input  logic               in_lr,
    input  logic               in_al,
    output logic [WIDTH-1:0]   sh_din,
    output logic [SHAMT_W-1:0] sh_shamt,
    output logic               sh_lr,
    output logic               sh_al,
    input  logic [WIDTH-1:0]   sh_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         pass_cnt,
    output logic               busy
);

    import shift_seq_pkg::*;

    localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(2**SHAMT_W - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [AMT_W-1:0]   rem_q;
    logic               lr_q;
    logic               al_q;
    logic [2:0]         pass_cnt_q;
    logic [SHAMT_W-1:0] step;
    logic               last_pass;

    // rem is zero outside PASS, so the step is naturally 0 in IDLE/DONE.
    assign last_pass = (rem_q <= STEP_MAX);
    assign step      = last_pass ? rem_q[SHAMT_W-1:0] : SHAMT_W'(STEP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            work_q     <= '0;
            rem_q      <= '0;
            lr_q       <= 1'b0;
            al_q       <= 1'b0;
            pass_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        work_q     <= in_din;
                        rem_q      <= in_amt;
                        lr_q       <= in_lr;
                        al_q       <= in_al;
                        pass_cnt_q <= '0;
                        state_q    <= StPass;
                    end
                end
                StPass: begin
                    work_q     <= sh_dout;
                    rem_q      <= rem_q - AMT_W'(step);
                    pass_cnt_q <= pass_cnt_q + 3'd1;
                    if (last_pass) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign sh_din    = work_q;
    assign sh_shamt  = step;
    assign sh_lr     = lr_q;
    assign sh_al     = al_q;
    assign out_data  = work_q;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq driving a real barrel_shifter instance.
// Expected values are hand-computed per command.
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_din;
    logic [4:0] in_amt;
    logic       in_lr;
    logic       in_al;
    logic [7:0] sh_din;
    logic [2:0] sh_shamt;
    logic       sh_lr;
    logic       sh_al;
    logic [7:0] sh_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] pass_cnt;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din    (in_din),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .in_al     (in_al),
        .sh_din    (sh_din),
        .sh_shamt  (sh_shamt),
        .sh_lr     (sh_lr),
        .sh_al     (sh_al),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pass_cnt  (pass_cnt),
        .busy      (busy)
    );

    barrel_shifter u_shifter (
        .din   (sh_din),
        .shamt (sh_shamt),
        .LR    (sh_lr),
        .AL    (sh_al),
        .dout  (sh_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the accepting edge has passed.
    task automatic start_cmd(input logic [7:0] din, input logic [4:0] amt,
                             input logic lr, input logic al);
        int n;
        in_din   = din;
        in_amt   = amt;
        in_lr    = lr;
        in_al    = al;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("accept_wait", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Walk the PASS cycles; shseq holds the expected per-pass amount, pass 0 in the low bits.
    task automatic run_passes(input string tag, input int passes, input logic [14:0] shseq);
        for (int i = 0; i < passes; i++) begin
            check_eq({tag, "_shamt"}, 32'(sh_shamt), 32'(shseq[3*i +: 3]));
            check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            check_eq({tag, "_novalid"}, 32'(out_valid), 32'd0);
            step();
        end
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] din, input logic [4:0] amt,
                           input logic lr, input logic al, input logic [7:0] exp,
                           input int passes, input logic [14:0] shseq);
        start_cmd(din, amt, lr, al);
        run_passes(tag, passes, shseq);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
        check_eq({tag, "_passes"}, 32'(pass_cnt), 32'(passes));
        check_eq({tag, "_inready_done"}, 32'(in_ready), 32'd0);
        step();
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_hold_data"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_din    = '0;
        in_amt    = '0;
        in_lr     = 1'b0;
        in_al     = 1'b0;
        out_ready = 1'b1;

        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_shamt", 32'(sh_shamt), 32'd0);
        check_eq("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        step();

        run_cmd("c1_left3", 8'hB4, 5'd3, 1'b1, 1'b0, 8'hA0, 1, 15'({3'd3}));
        run_cmd("c2_asr10", 8'h80, 5'd10, 1'b0, 1'b1, 8'hFF, 2, 15'({3'd3, 3'd7}));
        run_cmd("c3_amt0", 8'h96, 5'd0, 1'b0, 1'b0, 8'h96, 1, 15'd0);
        run_cmd("c4_lsr31", 8'h81, 5'd31, 1'b0, 1'b0, 8'h00, 5,
                {3'd3, 3'd7, 3'd7, 3'd7, 3'd7});
        run_cmd("c4b_asr9_pos", 8'h7F, 5'd9, 1'b0, 1'b1, 8'h00, 2, 15'({3'd2, 3'd7}));

        // Backpressure: DONE must hold and refuse a queued command.
        out_ready = 1'b0;
        start_cmd(8'h80, 5'd10, 1'b0, 1'b1);
        run_passes("c5", 2, 15'({3'd3, 3'd7}));
        in_din   = 8'h03;
        in_amt   = 5'd2;
        in_lr    = 1'b1;
        in_al    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("c5_hold_valid", 32'(out_valid), 32'd1);
            check_eq("c5_hold_data", 32'(out_data), 32'hFF);
            check_eq("c5_hold_ready", 32'(in_ready), 32'd0);
            check_eq("c5_hold_passes", 32'(pass_cnt), 32'd2);
            step();
        end
        out_ready = 1'b1;
        step();
        check_eq("c5_release_valid", 32'(out_valid), 32'd0);
        check_eq("c5_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("c5_second_busy", 32'(busy), 32'd1);
        check_eq("c5_second_shamt", 32'(sh_shamt), 32'd2);
        step();
        check_eq("c5_second_valid", 32'(out_valid), 32'd1);
        check_eq("c5_second_data", 32'(out_data), 32'h0C);
        step();

        // Asynchronous reset in the middle of a long command.
        start_cmd(8'h81, 5'd31, 1'b0, 1'b0);
        step();
        check_eq("c6_second_pass_shamt", 32'(sh_shamt), 32'd7);
        check_eq("c6_second_pass_cnt", 32'(pass_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("c6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("c6_rst_busy", 32'(busy), 32'd0);
        check_eq("c6_rst_ready", 32'(in_ready), 32'd1);
        check_eq("c6_rst_pass_cnt", 32'(pass_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check_eq("c6_post_idle", 32'(busy), 32'd0);
        run_cmd("c6_after", 8'h01, 5'd1, 1'b1, 1'b0, 8'h02, 1, 15'({3'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
